axi_mem_traffic_gen: RTL
========================

# axi_mem_traffic_gen

Synthesizable AXI4 master that writes a parametrised region of DDR3 memory with a deterministic data pattern, reads it back, and compares every beat. It generalises our single-beat write/readback bring-up to multi-beat bursts, multiple bursts, selectable patterns, and hardware error counting. It sits between the board clock/reset domain and the MIG AXI slave port, and is gated on `init_calib_complete`.

## Interface
- DATA_W, 512, AXI data width in bits; multiple of 32.
- ADDR_W, 32, AXI address width.
- BURST_LEN, 8, beats per burst, 1..256; BURST_LEN*DATA_W/8 must divide 4096, so no burst crosses a 4 KB boundary.
- NUM_BURSTS, 16, bursts per pass, 1..65535.
- BASE_ADDR, 32'h8000_0000, first byte address; aligned to BURST_LEN*DATA_W/8.

- clk  in  1  single clock, also the AXI clock.
- reset  in  1  asynchronous, active-high; shared with the AXI interconnect.
- init_calib_complete  in  1  memory ready; `start` is ignored while low.
- start  in  1  one-cycle pulse that begins a pass.
- pattern_mode  in  2  0=incrementing, 1=inverted incrementing, 2=address-as-data, 3=same as 0; sampled at start.
- seed  in  32  pattern seed; sampled at start.
- m_axi_aw*  out  awaddr[ADDR_W], awlen[8], awsize[3], awburst[2], awvalid; awready in.
- m_axi_w*  out  wdata[DATA_W], wstrb[DATA_W/8], wlast, wvalid; wready in.
- m_axi_b*  in  bresp[2], bvalid; bready out.
- m_axi_ar*  out  araddr[ADDR_W], arlen[8], arsize[3], arburst[2], arvalid; arready in.
- m_axi_r*  in  rdata[DATA_W], rresp[2], rlast, rvalid; rready out.
- busy  out  1  high from start accept through the last read beat.
- done  out  1  high from end of pass until next accepted start.
- pass  out  1  valid when done; 1 if err_count==0.
- err_count  out  16  mismatching beats plus non-OKAY responses, saturating at 16'hFFFF.
- first_err_addr  out  ADDR_W  address of the first failing beat; 0 if none.

## Operation
- FSM states: IDLE -> WR_ADDR -> WR_DATA -> WR_RESP -> (next burst: WR_ADDR | last: RD_ADDR) -> RD_DATA -> (next burst: RD_ADDR | last: DONE). DONE -> WR_ADDR on an accepted start.
- A start is accepted only in IDLE or DONE with init_calib_complete=1. Acceptance clears err_count, first_err_addr, pass, and done.
- Only one transaction is outstanding at a time. All writes complete before the first read.
- Burst b address = BASE_ADDR + b*BURST_LEN*DATA_W/8. awlen/arlen = BURST_LEN-1. awsize/arsize = clog2(DATA_W/8). burst type = INCR (2'b01). wstrb = all ones.
- Global beat index k = b*BURST_LEN + beat. 32-bit lane i of the beat's data:
  - mode 0/3: seed + k*(DATA_W/32) + i, mod 2^32.
  - mode 1: bitwise inverse of mode 0.
  - mode 2: low 32 bits of the lane's byte address (beat address + 4*i).
- Read checking:
  - Each rdata beat is compared against the regenerated expected value.
  - A beat counts as 1 error if the data mismatches OR rresp != OKAY.
  - bresp != OKAY counts as 1 error.
  - rlast absent on the final beat, or present early, counts as 1 error; the beat counter governs burst end.
- first_err_addr latches only on the first error of a pass; bresp errors latch the burst address.
- pass = (err_count==0), registered on entry to DONE.

## Timing
- Reset values: all valids 0, bready 0, rready 0, busy 0, done 0, pass 0, err_count 0, first_err_addr 0, all address/data outputs 0. Reset clears the FSM to IDLE immediately.
- awvalid rises the cycle after start acceptance. Every valid holds, with stable payload, until its ready. No output depends combinationally on any ready.
- wvalid rises the cycle after the AW handshake. Back-to-back beats with wready=1 give one beat per cycle; wlast accompanies beat BURST_LEN-1.
- bready is high only in WR_RESP. rready is high only in RD_DATA.
- The error update is registered one cycle after the R handshake. done rises one cycle after the final R beat; busy falls the same cycle.
- A start pulse during busy is ignored.

## Test plan
- Ideal slave, defaults, mode 0, seed 0: 128 write beats, 128 read beats; first beat lane i = i; done with pass=1 and err_count=0.
- Slave corrupts bit 0 of read beat k=37, mode 2: err_count=1, first_err_addr=BASE_ADDR+37*64, pass=0.
- Random ready deassertion on all five channels, BURST_LEN=1, NUM_BURSTS=3: each payload stays stable while valid is high; pass=1.
- Slave returns SLVERR on every bresp, NUM_BURSTS=4: err_count=4; first_err_addr=BASE_ADDR.
- Async reset asserted mid-WR_DATA: all outputs return to reset values within the reset event; a subsequent start completes with pass=1.
- start with init_calib_complete=0, or during busy: no AW/AR activity and no change to the ongoing pass.

Source files
------------

// File: rtl/axi_mem_traffic_gen.sv
// AXI4 memory traffic generator: writes a deterministic pattern over a DDR region in
// INCR bursts, reads it back, and counts mismatching beats and non-OKAY responses.
module axi_mem_traffic_gen #(
  parameter int unsigned        DATA_W     = 512,
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        BURST_LEN  = 8,
  parameter int unsigned        NUM_BURSTS = 16,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = ADDR_W'(32'h8000_0000)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init_calib_complete,
  input  logic                  start,
  input  logic [1:0]            pattern_mode,
  input  logic [31:0]           seed,

  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,

  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,

  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,

  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,

  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,

  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_W-1:0]     first_err_addr
);

  localparam int unsigned LANES       = DATA_W / 32;
  localparam int unsigned BEAT_BYTES  = DATA_W / 8;
  localparam int unsigned BURST_BYTES = BURST_LEN * BEAT_BYTES;
  localparam int unsigned SIZE        = $clog2(BEAT_BYTES);
  localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [15:0] LAST_BURST  = 16'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         burst_q, burst_d;
  logic [7:0]          beat_q, beat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          mode_q, mode_d;
  logic [31:0]         seed_q, seed_d;
  logic [15:0]         err_q, err_d;
  logic [ADDR_W-1:0]   ferr_q, ferr_d;
  logic                pass_q, pass_d;

  logic                accept;
  logic [ADDR_W-1:0]   beat_addr;
  logic [31:0]         beat_idx;
  logic [DATA_W-1:0]   exp_data;
  logic [1:0]          err_inc;
  logic [ADDR_W-1:0]   err_at;
  logic                data_bad, last_bad;
  logic [16:0]         err_sum;

  function automatic logic [DATA_W-1:0] gen_beat(input logic [1:0]        mode,
                                                 input logic [31:0]       sd,
                                                 input logic [31:0]       k,
                                                 input logic [ADDR_W-1:0] baddr);
    logic [DATA_W-1:0] v;
    logic [31:0]       inc;
    logic [ADDR_W-1:0] la;
    v = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      inc = sd + k * 32'(LANES) + 32'(i);
      la  = baddr + ADDR_W'(4 * i);
      case (mode)
        2'd1:    v[i*32 +: 32] = ~inc;
        2'd2:    v[i*32 +: 32] = 32'(la);
        default: v[i*32 +: 32] = inc;
      endcase
    end
    return v;
  endfunction

  // The same generator drives write data and the read-back reference; it is a
  // function of the registered burst/beat counters only, so payloads stay stable.
  assign beat_addr = addr_q + ADDR_W'(beat_q) * ADDR_W'(BEAT_BYTES);
  assign beat_idx  = 32'(burst_q) * 32'(BURST_LEN) + 32'(beat_q);
  assign exp_data  = gen_beat(mode_q, seed_q, beat_idx, beat_addr);

  assign accept = ((state_q == IDLE) || (state_q == DONE)) && init_calib_complete && start;

  assign m_axi_awvalid = (state_q == WR_ADDR);
  assign m_axi_awaddr  = m_axi_awvalid ? addr_q : '0;
  assign m_axi_awlen   = LAST_BEAT;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awburst = 2'b01;

  assign m_axi_wvalid  = (state_q == WR_DATA);
  assign m_axi_wdata   = m_axi_wvalid ? exp_data : '0;
  assign m_axi_wstrb   = m_axi_wvalid ? '1 : '0;
  assign m_axi_wlast   = m_axi_wvalid && (beat_q == LAST_BEAT);

  assign m_axi_bready  = (state_q == WR_RESP);

  assign m_axi_arvalid = (state_q == RD_ADDR);
  assign m_axi_araddr  = m_axi_arvalid ? addr_q : '0;
  assign m_axi_arlen   = LAST_BEAT;
  assign m_axi_arsize  = 3'(SIZE);
  assign m_axi_arburst = 2'b01;

  assign m_axi_rready  = (state_q == RD_DATA);

  assign busy           = (state_q != IDLE) && (state_q != DONE);
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;

  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    mode_d   = mode_q;
    seed_d   = seed_q;
    err_d    = err_q;
    ferr_d   = ferr_q;
    pass_d   = pass_q;
    err_inc  = '0;
    err_at   = beat_addr;
    data_bad = 1'b0;
    last_bad = 1'b0;
    err_sum  = '0;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = WR_ADDR;
          burst_d = '0;
          beat_d  = '0;
          addr_d  = BASE_ADDR;
          mode_d  = pattern_mode;
          seed_d  = seed;
          err_d   = '0;
          ferr_d  = '0;
          pass_d  = 1'b0;
        end
      end
      WR_ADDR: begin
        if (m_axi_awready) begin
          state_d = WR_DATA;
          beat_d  = '0;
        end
      end
      WR_DATA: begin
        if (m_axi_wready) begin
          if (beat_q == LAST_BEAT) begin
            state_d = WR_RESP;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00) begin
            err_inc = 2'd1;
            err_at  = addr_q;
          end
          if (burst_q == LAST_BURST) begin
            state_d = RD_ADDR;
            burst_d = '0;
            addr_d  = BASE_ADDR;
          end else begin
            state_d = WR_ADDR;
            burst_d = burst_q + 16'd1;
            addr_d  = addr_q + ADDR_W'(BURST_BYTES);
          end
        end
      end
      RD_ADDR: begin
        if (m_axi_arready) begin
          state_d = RD_DATA;
          beat_d  = '0;
        end
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          // Data/resp fault and a misplaced rlast are counted separately; the
          // local beat counter, not rlast, decides where the burst ends.
          data_bad = (m_axi_rdata != exp_data) || (m_axi_rresp != 2'b00);
          last_bad = (m_axi_rlast != (beat_q == LAST_BEAT));
          err_inc  = {1'b0, data_bad} + {1'b0, last_bad};
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (burst_q == LAST_BURST) begin
              state_d = DONE;
            end else begin
              state_d = RD_ADDR;
              burst_d = burst_q + 16'd1;
              addr_d  = addr_q + ADDR_W'(BURST_BYTES);
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (err_inc != 2'd0) begin
      err_sum = {1'b0, err_q} + 17'(err_inc);
      err_d   = err_sum[16] ? '1 : err_sum[15:0];
      if (err_q == '0) begin
        ferr_d = err_at;
      end
    end

    if ((state_d == DONE) && (state_q != DONE)) begin
      pass_d = (err_d == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      burst_q <= '0;
      beat_q  <= '0;
      addr_q  <= '0;
      mode_q  <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      pass_q  <= pass_d;
    end
  end

endmodule
